// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter shared definitions
// FSM state encoding and arbitration mode codes
package ram_arbiter_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MERGE = 1'b1
   } state_e;

   localparam logic PRIO_RR    = 1'b0;
   localparam logic PRIO_FIXED = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way picker
// Round-robin on rr_last, or port 0 first in fixed mode
module rr_arbiter2
   import ram_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       mode,
   input  logic       rr_last,
   input  logic       enable,
   output logic [1:0] gnt
);

   // one-hot pick; on a tie the port not granted last wins
   always_comb begin
      gnt = 2'b00;
      if (enable) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
               if (mode == PRIO_FIXED || rr_last)
                  gnt = 2'b01;
               else
                  gnt = 2'b10;
            end
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two requesters onto one single-port RAM
// Partial writes become read-then-merge over two cycles
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 32,
   parameter int PRIO_MODE  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    p0_req,
   input  logic                    p0_we,
   input  logic [DATA_WIDTH/8-1:0] p0_be,
   input  logic [ADDR_WIDTH-1:0]   p0_addr,
   input  logic [DATA_WIDTH-1:0]   p0_wdata,
   output logic                    p0_gnt,
   output logic                    p0_rvalid,
   output logic [DATA_WIDTH-1:0]   p0_rdata,
   input  logic                    p1_req,
   input  logic                    p1_we,
   input  logic [DATA_WIDTH/8-1:0] p1_be,
   input  logic [ADDR_WIDTH-1:0]   p1_addr,
   input  logic [DATA_WIDTH-1:0]   p1_wdata,
   output logic                    p1_gnt,
   output logic                    p1_rvalid,
   output logic [DATA_WIDTH-1:0]   p1_rdata,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic                    ram_we,
   output logic [DATA_WIDTH-1:0]   ram_din,
   input  logic [DATA_WIDTH-1:0]   ram_dout
);

   localparam int   BW   = DATA_WIDTH / 8;
   localparam logic MODE = (PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR;

   state_e                  state_q, state_d;
   logic                    rr_last_q, rr_last_d;
   logic [1:0]              rvalid_q, rvalid_d;
   logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
   logic [BW-1:0]           lat_be_q, lat_be_d;
   logic [DATA_WIDTH-1:0]   lat_wdata_q, lat_wdata_d;

   logic [1:0]              gnt;
   logic                    arb_en;
   logic                    w_we;
   logic [BW-1:0]           w_be;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_wdata;
   logic [DATA_WIDTH-1:0]   merged;

   assign arb_en = rst_n && (state_q == ST_IDLE);

   rr_arbiter2 u_pick (
      .req     ({p1_req, p0_req}),
      .mode    (MODE),
      .rr_last (rr_last_q),
      .enable  (arb_en),
      .gnt     (gnt)
   );

   assign p0_gnt = gnt[0];
   assign p1_gnt = gnt[1];

   // winner's fields only; the losing port is never looked at
   assign w_we    = gnt[1] ? p1_we    : p0_we;
   assign w_be    = gnt[1] ? p1_be    : p0_be;
   assign w_addr  = gnt[1] ? p1_addr  : p0_addr;
   assign w_wdata = gnt[1] ? p1_wdata : p0_wdata;

   // byte merge of latched write data over the old RAM word
   for (genvar i = 0; i < BW; i++) begin : g_merge
      assign merged[8*i +: 8] = lat_be_q[i] ? lat_wdata_q[8*i +: 8]
                                            : ram_dout[8*i +: 8];
   end

   assign p0_rvalid = rvalid_q[0];
   assign p1_rvalid = rvalid_q[1];
   assign p0_rdata  = ram_dout;
   assign p1_rdata  = ram_dout;

   // next state, RAM drive and latch updates
   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      rvalid_d    = 2'b00;
      lat_addr_d  = lat_addr_q;
      lat_be_d    = lat_be_q;
      lat_wdata_d = lat_wdata_q;
      ram_addr    = w_addr;
      ram_we      = 1'b0;
      ram_din     = w_wdata;
      unique case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               rr_last_d = gnt[1];
               if (!w_we) begin
                  rvalid_d = gnt;
               end else if (&w_be) begin
                  ram_we = 1'b1;
               end else if (|w_be) begin
                  lat_addr_d  = w_addr;
                  lat_be_d    = w_be;
                  lat_wdata_d = w_wdata;
                  state_d     = ST_MERGE;
               end
            end
         end
         ST_MERGE: begin
            ram_addr = lat_addr_q;
            ram_we   = 1'b1;
            ram_din  = merged;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // state and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rr_last_q   <= 1'b1;
         rvalid_q    <= 2'b00;
         lat_addr_q  <= '0;
         lat_be_q    <= '0;
         lat_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         rvalid_q    <= rvalid_d;
         lat_addr_q  <= lat_addr_d;
         lat_be_q    <= lat_be_d;
         lat_wdata_q <= lat_wdata_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// ram_arbiter directed bench
// Round-robin and fixed-priority instances share stimulus
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [3:0]  p0_be, p1_be;
   logic [8:0]  p0_addr, p1_addr;
   logic [31:0] p0_wdata, p1_wdata;

   logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, ram_we;
   logic [31:0] p0_rdata, p1_rdata, ram_din, ram_dout;
   logic [8:0]  ram_addr;

   logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_ram_we;
   logic [31:0] f_p0_rdata, f_p1_rdata, f_ram_din, f_ram_dout;
   logic [8:0]  f_ram_addr;

   logic [31:0] mem   [512];
   logic [31:0] f_mem [512];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ram_arbiter #(.PRIO_MODE(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   ram_arbiter #(.PRIO_MODE(1)) u_fix (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_be(p0_be),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(f_p0_gnt), .p0_rvalid(f_p0_rvalid), .p0_rdata(f_p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_be(p1_be),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(f_p1_gnt), .p1_rvalid(f_p1_rvalid), .p1_rdata(f_p1_rdata),
      .ram_addr(f_ram_addr), .ram_we(f_ram_we),
      .ram_din(f_ram_din), .ram_dout(f_ram_dout)
   );

   // 512x32 RAM models, registered read returning old data on write
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   always @(posedge clk) begin
      if (f_ram_we) f_mem[f_ram_addr] <= f_ram_din;
      f_ram_dout <= f_mem[f_ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drop();
      p0_req = 1'b0;
      p1_req = 1'b0;
   endtask

   task automatic set0(input logic we, input logic [3:0] be,
                       input logic [8:0] a, input logic [31:0] d);
      p0_req = 1'b1; p0_we = we; p0_be = be;
      p0_addr = a; p0_wdata = d;
   endtask

   task automatic set1(input logic we, input logic [3:0] be,
                       input logic [8:0] a, input logic [31:0] d);
      p1_req = 1'b1; p1_we = we; p1_be = be;
      p1_addr = a; p1_wdata = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   // single granted access by port 1, full write
   task automatic wr1(input logic [8:0] a, input logic [31:0] d);
      set1(1'b1, 4'hF, a, d);
      step();
      drop();
   endtask

   initial begin
      rst_n = 1'b0;
      drop();
      p0_we = 0; p0_be = 0; p0_addr = 0; p0_wdata = 0;
      p1_we = 0; p1_be = 0; p1_addr = 0; p1_wdata = 0;
      step();
      // reset state: requests are ignored while rst_n is low
      set0(1'b0, 4'h0, 9'd1, 32'h0);
      #1;
      chk("rst_gnt0", {31'd0, p0_gnt}, 32'd0);
      chk("rst_we", {31'd0, ram_we}, 32'd0);
      chk("rst_rv", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      drop();
      step();
      rst_n = 1'b1;
      step();

      // 1: full write then read by port 0
      set0(1'b1, 4'hF, 9'd5, 32'hDEADBEEF);
      #1;
      chk("t1_wgnt", {31'd0, p0_gnt}, 32'd1);
      chk("t1_wwe", {31'd0, ram_we}, 32'd1);
      step();
      chk("t1_wrv", {31'd0, p0_rvalid}, 32'd0);
      set0(1'b0, 4'h0, 9'd5, 32'h0);
      #1;
      chk("t1_rgnt", {31'd0, p0_gnt}, 32'd1);
      chk("t1_rwe", {31'd0, ram_we}, 32'd0);
      step();
      drop();
      chk("t1_rv", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
      chk("t1_data", p0_rdata, 32'hDEADBEEF);
      step();
      chk("t1_rv_off", {31'd0, p0_rvalid}, 32'd0);

      // 2 and 4: both ports read continuously after a fresh reset
      wr1(9'd7, 32'h77777777);
      do_reset();
      set0(1'b0, 4'h0, 9'd5, 32'h0);
      set1(1'b0, 4'h0, 9'd7, 32'h0);
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("t2_gnt", {30'd0, p1_gnt, p0_gnt},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("t4_gnt", {30'd0, f_p1_gnt, f_p0_gnt}, 32'd1);
         step();
         chk("t2_rv", {30'd0, p1_rvalid, p0_rvalid},
             (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("t2_data", (k % 2 == 0) ? p0_rdata : p1_rdata,
             (k % 2 == 0) ? 32'hDEADBEEF : 32'h77777777);
         chk("t4_rv", {30'd0, f_p1_rvalid, f_p0_rvalid}, 32'd1);
      end
      drop();
      step();

      // 3: partial write by port 1, port 0 blocked during merge
      wr1(9'd9, 32'h11223344);
      set1(1'b1, 4'b0010, 9'd9, 32'h0000AA00);
      #1;
      chk("t3_gnt1", {30'd0, p1_gnt, p0_gnt}, 32'd2);
      chk("t3_rdwe", {31'd0, ram_we}, 32'd0);
      step();
      drop();
      set0(1'b0, 4'h0, 9'd9, 32'h0);
      #1;
      chk("t3_mgnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("t3_mwe", {31'd0, ram_we}, 32'd1);
      chk("t3_maddr", {23'd0, ram_addr}, 32'd9);
      chk("t3_mdin", ram_din, 32'h1122AA44);
      step();
      #1;
      chk("t3_rgnt", {31'd0, p0_gnt}, 32'd1);
      step();
      drop();
      chk("t3_rv", {31'd0, p0_rvalid}, 32'd1);
      chk("t3_data", p0_rdata, 32'h1122AA44);

      // 5: reset in the middle of a merge drops the write
      wr1(9'd2, 32'hA5A5A5A5);
      set1(1'b1, 4'b0001, 9'd2, 32'h000000FF);
      #1;
      chk("t5_gnt", {31'd0, p1_gnt}, 32'd1);
      step();
      drop();
      #1;
      chk("t5_mwe", {31'd0, ram_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rstwe", {31'd0, ram_we}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("t5_rv", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      set0(1'b0, 4'h0, 9'd2, 32'h0);
      step();
      drop();
      chk("t5_rv2", {31'd0, p0_rvalid}, 32'd1);
      chk("t5_data", p0_rdata, 32'hA5A5A5A5);

      // 6: be=0 write is a granted no-op
      wr1(9'd3, 32'hCAFEF00D);
      set0(1'b1, 4'h0, 9'd3, 32'h12345678);
      #1;
      chk("t6_gnt", {31'd0, p0_gnt}, 32'd1);
      chk("t6_we", {31'd0, ram_we}, 32'd0);
      step();
      drop();
      #1;
      chk("t6_we2", {31'd0, ram_we}, 32'd0);
      chk("t6_rv", {31'd0, p0_rvalid}, 32'd0);
      set0(1'b0, 4'h0, 9'd3, 32'h0);
      step();
      drop();
      chk("t6_rv2", {31'd0, p0_rvalid}, 32'd1);
      chk("t6_data", p0_rdata, 32'hCAFEF00D);

      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
